// File: rtl/core_sequencer.sv
// rtl/core_sequencer.sv - multi-cycle FETCH/DECODE/EXEC/MEM/WB control FSM for the RV32I core
//
// Ports:
//   clk, rst                        core clock, asynchronous active-low reset
//   run, step                       debug control: free-run level, single-step pulse
//   imem_req / imem_ack             instruction fetch handshake
//   ir_we                           latch instruction word into decoder
//   is_load, is_store, wb_en        decoded instruction class (valid from DECODE on)
//   dmem_req, dmem_we / dmem_ack    data memory handshake
//   rf_we, pc_we                    regfile write / PC advance strobes
//   halted, fault, state, retired   status and debug observation
module core_sequencer #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic             step,
    output logic             imem_req,
    input  logic             imem_ack,
    output logic             ir_we,
    input  logic             is_load,
    input  logic             is_store,
    input  logic             wb_en,
    output logic             dmem_req,
    output logic             dmem_we,
    input  logic             dmem_ack,
    output logic             rf_we,
    output logic             pc_we,
    output logic             halted,
    output logic             fault,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_FAULT  = 3'd7
    } state_t;

    // The counter only has to reach TIMEOUT-1: the cycle that would make it
    // TIMEOUT is the one that leaves for FAULT instead.
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] WAIT_LAST = CW'(TIMEOUT - 1);

    state_t          state_q, state_d;
    logic [CW-1:0]   wait_cnt;
    logic            step_q;
    logic [CNT_W-1:0] retired_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            wait_cnt  <= '0;
            step_q    <= 1'b0;
            retired_q <= '0;
        end else begin
            state_q <= state_d;

            // Wait counter restarts on every state change so each FETCH/MEM
            // visit gets a full TIMEOUT budget.
            if (state_d != state_q)
                wait_cnt <= '0;
            else if (state_q == S_FETCH || state_q == S_MEM)
                wait_cnt <= wait_cnt + 1'b1;

            // Single-step flag is only armed from IDLE while not free-running,
            // so pulses during an instruction or with run=1 are dropped.
            if (state_q == S_IDLE && step && !run)
                step_q <= 1'b1;
            else if (state_q == S_WB)
                step_q <= 1'b0;

            if (state_q == S_WB)
                retired_q <= retired_q + CNT_W'(1);
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (run || step) state_d = S_FETCH;
            S_FETCH: begin
                if (imem_ack)                   state_d = S_DECODE;
                else if (wait_cnt == WAIT_LAST) state_d = S_FAULT;
            end
            S_DECODE: state_d = S_EXEC;
            S_EXEC:   state_d = (is_load || is_store) ? S_MEM : S_WB;
            S_MEM: begin
                if (dmem_ack)                   state_d = S_WB;
                else if (wait_cnt == WAIT_LAST) state_d = S_FAULT;
            end
            S_WB:     state_d = (run && !step_q) ? S_FETCH : S_IDLE;
            S_FAULT:  state_d = S_FAULT;
            default:  state_d = S_FAULT;
        endcase
    end

    // Moore decode of the state register; reset forces IDLE so every strobe
    // drops as soon as rst falls.
    always_comb begin
        imem_req = (state_q == S_FETCH);
        ir_we    = (state_q == S_DECODE);
        dmem_req = (state_q == S_MEM);
        dmem_we  = (state_q == S_MEM) && is_store;
        rf_we    = (state_q == S_WB) && wb_en && !is_store;
        pc_we    = (state_q == S_WB);
        halted   = (state_q == S_IDLE);
        fault    = (state_q == S_FAULT);
    end

    assign state   = state_q;
    assign retired = retired_q;

endmodule
